muldiv_issue: RTL and testbench
===============================

Name: muldiv_issue

Overview:
- Execute-stage initiator for the M-extension multiply/divide unit.
- Accepts an M-type instruction from the pipeline and decodes funct3 into the unit's op_mul/op_div/muldiv_sel controls.
- Launches the unit with a one-cycle start, holds operands stable, stalls the pipeline until done, then presents the result to writeback.
- Keeps a one-entry result cache so a repeated identical operation completes without launching the unit.

Parameters:
CACHE_EN, 1, 1 enables the one-entry operand-match result cache; 0 forces every op through the unit.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous active-low reset
ex_valid  input  1  M-type instruction present in EX
ex_funct3  input  3  RISC-V M funct3 (000 MUL … 111 REMU)
ex_rs1  input  32  operand A
ex_rs2  input  32  operand B
ex_rd  input  5  destination register
flush  input  1  kill the instruction currently in EX
stall_o  output  1  hold pipeline
md_start  output  1  start pulse to mul/div unit
md_A  output  32  operand A to unit
md_B  output  32  operand B to unit
md_op_mul  output  2  funct3[1:0]
md_op_div  output  2  funct3[1:0]; [1]=remainder, [0]=unsigned
md_sel  output  1  funct3[2]; 1=divide, 0=multiply
md_R  input  32  unit result, valid while md_done=1
md_done  input  1  unit completion
wb_valid  output  1  one-cycle result valid to writeback
wb_rd  output  5  destination register of result
wb_data  output  32  result

Behaviour:
- Clock and reset: single clock clk; reset asynchronous, active-low.
- Reset values: state=IDLE; all outputs 0; operand, funct3 and rd registers 0; cache invalid.
- md_A, md_B, md_op_*, md_sel are driven from internal registers loaded only on accept. They stay stable from md_start until md_done.
- States: IDLE, BUSY, DRAIN, RESP.
- IDLE, accept condition: ex_valid=1 and flush=0.
  - On accept, latch funct3/rs1/rs2/rd.
  - Cache hit (CACHE_EN=1, cache valid, funct3/rs1/rs2 all equal tag): wb_data<=cached value, go to RESP. md_start is never asserted.
  - Cache miss: md_start<=1 for exactly the next cycle, go to BUSY.
  - stall_o=1 combinationally in the accept cycle.
  - ex_valid=1 with flush=1 in IDLE: no accept, stall_o=0.
- BUSY: stall_o=1; md_start=1 only in the first BUSY cycle.
  - md_done=1: wb_data<=md_R, cache tag<=latched funct3/rs1/rs2, cache data<=md_R, cache valid<=1, go to RESP.
  - flush=1 without md_done: go to DRAIN. The unit cannot be aborted.
  - flush=1 and md_done=1 in the same cycle: go to IDLE, no writeback, cache updated.
- DRAIN: stall_o=ex_valid, so a new instruction waits. md_done=1: go to IDLE, discard md_R, cache not updated. flush has no further effect.
- RESP: wb_valid=1, wb_rd=latched rd, stall_o=0 for one cycle; next state IDLE. The held instruction leaves EX at the end of this cycle and is never re-accepted.
  - flush=1 in RESP: wb_valid forced 0.
- Latency from accept to wb_valid:
  - cache hit: 1 cycle;
  - miss: unit latency + 2 cycles (start cycle + RESP).
- md_done outside BUSY/DRAIN is ignored.
- Reset mid-operation returns to IDLE immediately with cache invalid. The unit shares the same reset.
- No arithmetic in this block. Divide-by-zero and overflow results come from the unit unmodified.

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD (−3) -> md_start one cycle with md_op_mul=00, md_sel=0; stall_o held until md_done; wb_valid one cycle with wb_data=0xFFFFFFEB, wb_rd as issued.
- DIVU 100/7, then DIVU 100/7 again -> first: md_start pulsed, wb_data=14. Second: md_start stays 0, wb_valid one cycle after accept, wb_data=14. With CACHE_EN=0, both launch the unit.
- DIVU 100/7, then REMU 100/7 -> cache miss on funct3; md_start pulsed, md_op_div=11, md_sel=1, wb_data=2.
- DIV issued, flush in 2nd BUSY cycle, next MULHU 0xFFFFFFFF*2 presented -> no wb_valid for the DIV; stall_o=1 while in DRAIN; MULHU accepted only after md_done; wb_data=0x00000001.
- Flush asserted on the accept cycle, and flush in RESP -> no md_start on the accept case; wb_valid=0 on the RESP case.
- Reset asserted mid-BUSY -> all outputs 0 asynchronously. A repeat of the prior op after reset launches the unit (cache invalid).

Source files
------------

// File: rtl/muldiv_issue.sv
// Execute-stage initiator for the M-extension multiply/divide unit: decodes
// funct3, launches the unit, stalls until done and hands the result to writeback.
module muldiv_issue #(
  parameter bit CACHE_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_rs1,
  input  logic [31:0] ex_rs2,
  input  logic [4:0]  ex_rd,
  input  logic        flush,
  output logic        stall_o,
  output logic        md_start,
  output logic [31:0] md_A,
  output logic [31:0] md_B,
  output logic [1:0]  md_op_mul,
  output logic [1:0]  md_op_div,
  output logic        md_sel,
  input  logic [31:0] md_R,
  input  logic        md_done,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data
);

  typedef enum logic [1:0] {IDLE, BUSY, DRAIN, RESP} state_t;

  state_t      state_q;
  logic [2:0]  f3_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [4:0]  rd_q;
  logic        start_q;
  logic [31:0] wb_data_q;

  logic        cv_q;
  logic [2:0]  ct_f3_q;
  logic [31:0] ct_a_q;
  logic [31:0] ct_b_q;
  logic [31:0] cd_q;

  logic accept;
  logic hit;

  assign accept = (state_q == IDLE) && ex_valid && !flush;
  assign hit    = CACHE_EN && cv_q && (ct_f3_q == ex_funct3) &&
                  (ct_a_q == ex_rs1) && (ct_b_q == ex_rs2);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      f3_q      <= 3'd0;
      a_q       <= 32'd0;
      b_q       <= 32'd0;
      rd_q      <= 5'd0;
      start_q   <= 1'b0;
      wb_data_q <= 32'd0;
      cv_q      <= 1'b0;
      ct_f3_q   <= 3'd0;
      ct_a_q    <= 32'd0;
      ct_b_q    <= 32'd0;
      cd_q      <= 32'd0;
    end else begin
      start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            f3_q <= ex_funct3;
            a_q  <= ex_rs1;
            b_q  <= ex_rs2;
            rd_q <= ex_rd;
            if (hit) begin
              wb_data_q <= cd_q;
              state_q   <= RESP;
            end else begin
              start_q <= 1'b1;
              state_q <= BUSY;
            end
          end
        end
        BUSY: begin
          // A completed result is cached even when the instruction was flushed.
          if (md_done) begin
            ct_f3_q <= f3_q;
            ct_a_q  <= a_q;
            ct_b_q  <= b_q;
            cd_q    <= md_R;
            cv_q    <= CACHE_EN;
            if (flush) begin
              state_q <= IDLE;
            end else begin
              wb_data_q <= md_R;
              state_q   <= RESP;
            end
          end else if (flush) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (md_done) state_q <= IDLE;
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    stall_o = 1'b0;
    case (state_q)
      IDLE:    stall_o = accept;
      BUSY:    stall_o = 1'b1;
      DRAIN:   stall_o = ex_valid;
      RESP:    stall_o = 1'b0;
      default: stall_o = 1'b0;
    endcase
  end

  assign md_start  = start_q;
  assign md_A      = a_q;
  assign md_B      = b_q;
  assign md_op_mul = f3_q[1:0];
  assign md_op_div = f3_q[1:0];
  assign md_sel    = f3_q[2];
  assign wb_valid  = (state_q == RESP) && !flush;
  assign wb_rd     = rd_q;
  assign wb_data   = wb_data_q;

endmodule

// File: tb/tb_muldiv_issue.sv
// Directed bench for muldiv_issue: the bench plays the mul/div unit with
// hand-computed results and checks launch, stall, drain, cache and reset behaviour.
module tb_muldiv_issue;

  logic        clk;
  logic        reset;
  logic        ex_valid;
  logic        ex_valid_n;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_rs1;
  logic [31:0] ex_rs2;
  logic [4:0]  ex_rd;
  logic        flush;
  logic [31:0] md_R;
  logic        md_done;

  logic        stall_o, md_start, md_sel, wb_valid;
  logic [31:0] md_A, md_B, wb_data;
  logic [1:0]  md_op_mul, md_op_div;
  logic [4:0]  wb_rd;

  logic        n_stall_o, n_md_start, n_md_sel, n_wb_valid;
  logic [31:0] n_md_A, n_md_B, n_wb_data;
  logic [1:0]  n_md_op_mul, n_md_op_div;
  logic [4:0]  n_wb_rd;

  int n_cmp = 0;
  int n_err = 0;

  muldiv_issue #(.CACHE_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_funct3(ex_funct3),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .flush(flush),
    .stall_o(stall_o), .md_start(md_start), .md_A(md_A), .md_B(md_B),
    .md_op_mul(md_op_mul), .md_op_div(md_op_div), .md_sel(md_sel),
    .md_R(md_R), .md_done(md_done), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .wb_data(wb_data)
  );

  muldiv_issue #(.CACHE_EN(1'b0)) dut_nc (
    .clk(clk), .reset(reset), .ex_valid(ex_valid_n), .ex_funct3(ex_funct3),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .flush(flush),
    .stall_o(n_stall_o), .md_start(n_md_start), .md_A(n_md_A), .md_B(n_md_B),
    .md_op_mul(n_md_op_mul), .md_op_div(n_md_op_div), .md_sel(n_md_sel),
    .md_R(md_R), .md_done(md_done), .wb_valid(n_wb_valid), .wb_rd(n_wb_rd),
    .wb_data(n_wb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // Issue one op that must miss the cache; the bench answers as the unit after
  // lat extra BUSY cycles. With kill set, flush is raised in the RESP cycle.
  task automatic run_miss(input string tag, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [31:0] r,
                          input logic [1:0] exp_op, input logic exp_sel,
                          input int lat, input logic kill, input logic exp_wbv);
    ex_valid = 1'b1; ex_funct3 = f3; ex_rs1 = a; ex_rs2 = b; ex_rd = rd;
    #1;
    chk({tag, ".stall_accept"}, stall_o, 1);
    chk({tag, ".nostart_accept"}, md_start, 0);
    cyc();
    chk({tag, ".start"}, md_start, 1);
    chk({tag, ".A"}, md_A, a);
    chk({tag, ".B"}, md_B, b);
    chk({tag, ".op_mul"}, md_op_mul, exp_op);
    chk({tag, ".op_div"}, md_op_div, exp_op);
    chk({tag, ".sel"}, md_sel, exp_sel);
    chk({tag, ".stall_busy"}, stall_o, 1);
    for (int i = 0; i < lat; i++) begin
      cyc();
      chk({tag, ".start_low"}, md_start, 0);
      chk({tag, ".stall_wait"}, stall_o, 1);
      chk({tag, ".A_hold"}, md_A, a);
    end
    md_done = 1'b1; md_R = r;
    cyc();
    md_done = 1'b0; md_R = 32'd0; flush = kill;
    #1;
    chk({tag, ".wb_valid"}, wb_valid, exp_wbv);
    chk({tag, ".wb_data"}, wb_data, r);
    chk({tag, ".wb_rd"}, wb_rd, rd);
    chk({tag, ".stall_resp"}, stall_o, 0);
    ex_valid = 1'b0; flush = 1'b0;
    cyc();
    chk({tag, ".wb_done"}, wb_valid, 0);
    chk({tag, ".no_relaunch"}, md_start, 0);
  endtask

  task automatic run_hit(input string tag, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] r);
    ex_valid = 1'b1; ex_funct3 = f3; ex_rs1 = a; ex_rs2 = b; ex_rd = rd;
    #1;
    chk({tag, ".stall_accept"}, stall_o, 1);
    cyc();
    chk({tag, ".nostart"}, md_start, 0);
    chk({tag, ".wb_valid"}, wb_valid, 1);
    chk({tag, ".wb_data"}, wb_data, r);
    chk({tag, ".wb_rd"}, wb_rd, rd);
    ex_valid = 1'b0;
    cyc();
    chk({tag, ".wb_done"}, wb_valid, 0);
    chk({tag, ".nostart2"}, md_start, 0);
  endtask

  initial begin
    reset = 1'b0; ex_valid = 1'b0; ex_valid_n = 1'b0; ex_funct3 = 3'd0;
    ex_rs1 = 32'd0; ex_rs2 = 32'd0; ex_rd = 5'd0; flush = 1'b0;
    md_R = 32'd0; md_done = 1'b0;
    cyc(); cyc();
    chk("rst.stall", stall_o, 0);
    chk("rst.start", md_start, 0);
    chk("rst.A", md_A, 0);
    chk("rst.B", md_B, 0);
    chk("rst.sel", md_sel, 0);
    chk("rst.wb_valid", wb_valid, 0);
    chk("rst.wb_data", wb_data, 0);
    chk("rst.wb_rd", wb_rd, 0);
    reset = 1'b1;
    cyc();

    // MUL 7 * -3 = -21
    run_miss("mul", 3'b000, 32'd7, 32'hFFFFFFFD, 5'd5, 32'hFFFFFFEB, 2'b00, 1'b0, 3, 1'b0, 1'b1);
    // DIVU 100/7 twice: second must come from the cache
    run_miss("divu", 3'b101, 32'd100, 32'd7, 5'd6, 32'd14, 2'b01, 1'b1, 2, 1'b0, 1'b1);
    run_hit("divu_hit", 3'b101, 32'd100, 32'd7, 5'd6, 32'd14);
    // REMU 100/7 differs only in funct3
    run_miss("remu", 3'b111, 32'd100, 32'd7, 5'd7, 32'd2, 2'b11, 1'b1, 1, 1'b0, 1'b1);

    // DIV flushed in its second BUSY cycle, MULHU waits behind the drain
    ex_valid = 1'b1; ex_funct3 = 3'b100; ex_rs1 = 32'hFFFFFFEC; ex_rs2 = 32'd3; ex_rd = 5'd8;
    cyc();
    chk("div.start", md_start, 1);
    chk("div.op_div", md_op_div, 2'b00);
    chk("div.sel", md_sel, 1);
    cyc();
    flush = 1'b1;
    #1;
    chk("div.stall_flush", stall_o, 1);
    cyc();
    flush = 1'b0; ex_funct3 = 3'b011; ex_rs1 = 32'hFFFFFFFF; ex_rs2 = 32'd2; ex_rd = 5'd9;
    #1;
    chk("drain.stall", stall_o, 1);
    chk("drain.wb_valid", wb_valid, 0);
    chk("drain.A_hold", md_A, 32'hFFFFFFEC);
    chk("drain.start", md_start, 0);
    cyc();
    chk("drain.stall2", stall_o, 1);
    chk("drain.wb_valid2", wb_valid, 0);
    md_done = 1'b1; md_R = 32'hDEADBEEF;
    cyc();
    md_done = 1'b0; md_R = 32'd0;
    #1;
    chk("drain.no_wb", wb_valid, 0);
    run_miss("mulhu", 3'b011, 32'hFFFFFFFF, 32'd2, 5'd9, 32'h00000001, 2'b11, 1'b0, 0, 1'b0, 1'b1);

    // Flush on the accept cycle: nothing launches
    ex_valid = 1'b1; flush = 1'b1; ex_funct3 = 3'b000; ex_rs1 = 32'd3; ex_rs2 = 32'd4; ex_rd = 5'd10;
    #1;
    chk("flush_acc.stall", stall_o, 0);
    cyc();
    chk("flush_acc.start", md_start, 0);
    chk("flush_acc.wb_valid", wb_valid, 0);
    ex_valid = 1'b0; flush = 1'b0;
    cyc();
    chk("flush_acc.start2", md_start, 0);

    // Flush in RESP suppresses the writeback; the result is still cached
    run_miss("flush_resp", 3'b000, 32'd3, 32'd4, 5'd10, 32'd12, 2'b00, 1'b0, 1, 1'b1, 1'b0);

    // Non-caching instance launches the unit for both identical DIVUs
    for (int i = 0; i < 2; i++) begin
      ex_valid_n = 1'b1; ex_funct3 = 3'b101; ex_rs1 = 32'd100; ex_rs2 = 32'd7; ex_rd = 5'd6;
      cyc();
      chk($sformatf("nocache%0d.start", i), n_md_start, 1);
      chk($sformatf("nocache%0d.main_idle", i), md_start, 0);
      md_done = 1'b1; md_R = 32'd14;
      cyc();
      md_done = 1'b0; md_R = 32'd0;
      chk($sformatf("nocache%0d.wb_valid", i), n_wb_valid, 1);
      chk($sformatf("nocache%0d.wb_data", i), n_wb_data, 14);
      chk($sformatf("nocache%0d.main_wb", i), wb_valid, 0);
      ex_valid_n = 1'b0;
      cyc();
    end

    // Cached MUL 3*4, then reset during a DIVU's BUSY
    run_hit("mul_hit", 3'b000, 32'd3, 32'd4, 5'd11, 32'd12);
    ex_valid = 1'b1; ex_funct3 = 3'b101; ex_rs1 = 32'd100; ex_rs2 = 32'd7; ex_rd = 5'd6;
    cyc();
    chk("rstb.start", md_start, 1);
    ex_valid = 1'b0; reset = 1'b0;
    #1;
    chk("rstb.start0", md_start, 0);
    chk("rstb.stall", stall_o, 0);
    chk("rstb.A", md_A, 0);
    chk("rstb.B", md_B, 0);
    chk("rstb.sel", md_sel, 0);
    chk("rstb.op_div", md_op_div, 0);
    chk("rstb.wb_valid", wb_valid, 0);
    chk("rstb.wb_data", wb_data, 0);
    chk("rstb.wb_rd", wb_rd, 0);
    cyc();
    reset = 1'b1;
    cyc();

    // md_done while idle is ignored
    md_done = 1'b1; md_R = 32'd55;
    cyc();
    md_done = 1'b0; md_R = 32'd0;
    chk("idle_done.wb_valid", wb_valid, 0);
    chk("idle_done.stall", stall_o, 0);
    chk("idle_done.wb_data", wb_data, 0);

    // Cache was invalidated by reset: the repeat must launch the unit
    run_miss("mul_after_rst", 3'b000, 32'd3, 32'd4, 5'd11, 32'd12, 2'b00, 1'b0, 1, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
